// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO-side arbitration blocks.
package fifo_pkg;

  typedef enum logic {IDLE, GRANT} state_e;

  // Source-tag width; a single requester still needs one tag bit.
  function automatic int tag_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first valid index after last_i, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [ID_W-1:0]    last_i,
  output logic [ID_W-1:0]    winner_o,
  output logic               any_o
);

  logic            found;
  logic [ID_W-1:0] idx;

  // Walk last+1 .. last+NUM_REQ so last_i itself is checked last.
  always_comb begin
    winner_o = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(last_i) + k) % NUM_REQ);
      if (!found && valid_i[idx]) begin
        winner_o = idx;
        found    = 1'b1;
      end
    end
  end

  assign any_o = |valid_i;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter driving one FIFO write port; words tagged with source id.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int MAX_BURST  = 4,
  localparam int ID_W       = tag_w(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [ID_W+DATA_WIDTH-1:0]    fifo_data_in,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   pick;
  logic              any_vld;
  logic              own_vld;
  logic              xfer;

  rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .valid_i  (req_valid),
    .last_i   (last_q),
    .winner_o (pick),
    .any_o    (any_vld)
  );

  assign busy         = (state_q == GRANT);
  assign grant_id     = owner_q;
  assign own_vld      = req_valid[owner_q];
  assign xfer         = busy && own_vld && !fifo_full;
  assign fifo_wr_en   = xfer;
  assign fifo_data_in = {owner_q, req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH]};

  always_comb begin
    req_ready = '0;
    if (busy) req_ready[owner_q] = !fifo_full;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (any_vld) begin
          state_d = GRANT;
          owner_d = pick;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        // A full FIFO only stalls; release comes from dropout or burst end.
        if (!own_vld) begin
          state_d = IDLE;
          last_d  = owner_q;
        end else if (xfer) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(MAX_BURST - 1)) begin
            state_d = IDLE;
            last_d  = owner_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= ID_W'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and random checks of fifo_wr_arbiter: burst order, stalls, dropout, reset, fairness.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int MB = 4;
  localparam int IW = 2;
  localparam int WAIT_MAX = (NR - 1) * (MB + 1) + 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NR-1:0]      req_valid;
  logic [NR*DW-1:0]   req_data;
  logic [NR-1:0]      req_ready;
  logic               fifo_full;
  logic               fifo_wr_en;
  logic [IW+DW-1:0]   fifo_data_in;
  logic [IW-1:0]      grant_id;
  logic               busy;

  int checks = 0;
  int errors = 0;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_data  = '0;
    fifo_full = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_ready, fifo_wr_en, busy, grant_id} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b wr=%b busy=%b gid=%0d, expected all 0",
               req_ready, fifo_wr_en, busy, grant_id);
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b wr=%b, expected 0 0", busy, fifo_wr_en);
    end
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0001;
    req_data[0 +: DW] = 32'hA0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || fifo_wr_en !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL single_bubble: got busy=%b wr=%b ready=%b, expected 0 0 0000", busy, fifo_wr_en, req_ready);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      req_data[0 +: DW] = 32'hA0 + k;
      @(negedge clk);
      checks++;
      if (fifo_wr_en !== 1'b1 || fifo_data_in !== {2'd0, 32'hA0 + k} || req_ready !== 4'b0001) begin
        errors++;
        $display("FAIL single_beat%0d: got wr=%b data=%h ready=%b, expected 1 %h 0001",
                 k, fifo_wr_en, fifo_data_in, req_ready, {2'd0, 32'hA0 + k});
      end
    end
    tick();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL single_end_idle: got busy=%b wr=%b, expected 0 0", busy, fifo_wr_en);
    end
  endtask

  task automatic test_all_valid();
    logic [IW-1:0] exp_id;
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 32'hC000 + i;
    for (int b = 0; b < 5; b++) begin
      exp_id = IW'(b % NR);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin
        errors++;
        $display("FAIL rr_gap%0d: got busy=%b wr=%b, expected 0 0", b, busy, fifo_wr_en);
      end
      for (int k = 0; k < MB; k++) begin
        tick();
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || grant_id !== exp_id || fifo_wr_en !== 1'b1 ||
            fifo_data_in !== {exp_id, 32'hC000 + 32'(b % NR)}) begin
          errors++;
          $display("FAIL rr_burst%0d_beat%0d: got busy=%b gid=%0d wr=%b data=%h, expected 1 %0d 1 %h",
                   b, k, busy, grant_id, fifo_wr_en, fifo_data_in, exp_id, {exp_id, 32'hC000 + 32'(b % NR)});
        end
      end
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_full_stall();
    do_reset();
    req_valid = 4'b0100;
    req_data[2*DW +: DW] = 32'hD0;
    tick();
    for (int k = 0; k < 2; k++) begin
      req_data[2*DW +: DW] = 32'hD0 + k;
      @(negedge clk);
      checks++;
      if (fifo_wr_en !== 1'b1 || grant_id !== 2'd2 || fifo_data_in !== {2'd2, 32'hD0 + k}) begin
        errors++;
        $display("FAIL stall_pre%0d: got wr=%b gid=%0d data=%h, expected 1 2 %h",
                 k, fifo_wr_en, grant_id, fifo_data_in, {2'd2, 32'hD0 + k});
      end
      tick();
    end
    req_data[2*DW +: DW] = 32'hD2;
    fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (fifo_wr_en !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_full%0d: got wr=%b ready=%b busy=%b, expected 0 0000 1", k, fifo_wr_en, req_ready, busy);
      end
      tick();
    end
    fifo_full = 1'b0;
    for (int k = 2; k < 4; k++) begin
      req_data[2*DW +: DW] = 32'hD0 + k;
      @(negedge clk);
      checks++;
      if (fifo_wr_en !== 1'b1 || req_ready !== 4'b0100 || fifo_data_in !== {2'd2, 32'hD0 + k}) begin
        errors++;
        $display("FAIL stall_post%0d: got wr=%b ready=%b data=%h, expected 1 0100 %h",
                 k, fifo_wr_en, req_ready, fifo_data_in, {2'd2, 32'hD0 + k});
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: got busy=%b wr=%b, expected 0 0", busy, fifo_wr_en);
    end
    req_valid = '0;
  endtask

  task automatic test_dropout();
    do_reset();
    req_valid = 4'b1010;
    req_data[1*DW +: DW] = 32'hE1;
    req_data[3*DW +: DW] = 32'hE3;
    tick();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (fifo_wr_en !== 1'b1 || grant_id !== 2'd1 || fifo_data_in !== {2'd1, 32'hE1}) begin
        errors++;
        $display("FAIL drop_beat%0d: got wr=%b gid=%0d data=%h, expected 1 1 %h",
                 k, fifo_wr_en, grant_id, fifo_data_in, {2'd1, 32'hE1});
      end
      tick();
    end
    req_valid = 4'b1000;
    @(negedge clk);
    checks++;
    if (fifo_wr_en !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_nowrite: got wr=%b busy=%b, expected 0 1", fifo_wr_en, busy);
    end
    tick();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_bubble: got busy=%b, expected 0", busy);
    end
    tick();
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || grant_id !== 2'd3 || fifo_wr_en !== 1'b1 || fifo_data_in !== {2'd3, 32'hE3}) begin
      errors++;
      $display("FAIL drop_next_owner: got busy=%b gid=%0d wr=%b data=%h, expected 1 3 1 %h",
               busy, grant_id, fifo_wr_en, fifo_data_in, {2'd3, 32'hE3});
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 4'b1011;
    req_data[0 +: DW] = 32'hB0;
    tick();
    for (int k = 0; k < 2; k++) begin
      req_data[0 +: DW] = 32'hB0 + k;
      @(negedge clk);
      checks++;
      if (fifo_wr_en !== 1'b1 || grant_id !== 2'd0 || fifo_data_in !== {2'd0, 32'hB0 + k}) begin
        errors++;
        $display("FAIL rstmid_beat%0d: got wr=%b gid=%0d data=%h, expected 1 0 %h",
                 k, fifo_wr_en, grant_id, fifo_data_in, {2'd0, 32'hB0 + k});
      end
      tick();
    end
    req_data[0 +: DW] = 32'hB2;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, fifo_wr_en, busy, grant_id} !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_async: got ready=%b wr=%b busy=%b gid=%0d, expected all 0",
               req_ready, fifo_wr_en, busy, grant_id);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || fifo_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_bubble: got busy=%b wr=%b, expected 0 0", busy, fifo_wr_en);
    end
    tick();
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || grant_id !== 2'd0 || fifo_data_in !== {2'd0, 32'hB2}) begin
      errors++;
      $display("FAIL rstmid_regrant: got busy=%b gid=%0d data=%h, expected 1 0 %h",
               busy, grant_id, fifo_data_in, {2'd0, 32'hB2});
    end
    req_valid = '0;
  endtask

  // Producers send {id, seq}; consumer side expects each source's seq in order.
  task automatic test_random();
    logic [NR-1:0] pv;
    int            pseq [NR];
    int            eseq [NR];
    int            waitc [NR];
    int            writes;
    logic [IW-1:0] tag;
    logic          nfull;
    do_reset();
    pv = '0;
    nfull = 1'b0;
    writes = 0;
    for (int i = 0; i < NR; i++) begin
      pseq[i] = 0; eseq[i] = 0; waitc[i] = 0;
    end
    for (int c = 0; c < 10000; c++) begin
      req_valid = pv;
      fifo_full = nfull;
      for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = {8'(i), 24'(pseq[i])};
      @(negedge clk);
      checks++;
      if (fifo_wr_en === 1'b1 && fifo_full === 1'b1) begin
        errors++;
        $display("FAIL rnd_write_while_full: cycle %0d got wr=1, expected 0", c);
      end
      checks++;
      if (!$onehot0(req_ready)) begin
        errors++;
        $display("FAIL rnd_ready_onehot: cycle %0d got ready=%b, expected one-hot or zero", c, req_ready);
      end
      if (fifo_wr_en === 1'b1) begin
        tag = fifo_data_in[DW +: IW];
        checks++;
        if (fifo_data_in[DW-1:0] !== {8'(tag), 24'(eseq[tag])}) begin
          errors++;
          $display("FAIL rnd_stream: cycle %0d src %0d got %h, expected %h",
                   c, tag, fifo_data_in[DW-1:0], {8'(tag), 24'(eseq[tag])});
        end
        eseq[tag]++;
        writes++;
      end
      for (int i = 0; i < NR; i++) begin
        if (pv[i] && req_ready[i]) begin
          pseq[i]++;
          waitc[i] = 0;
          pv[i] = ($urandom_range(3) != 0);
        end else if (pv[i]) begin
          if (!fifo_full) waitc[i]++;
          if (waitc[i] == WAIT_MAX + 1) begin
            checks++;
            errors++;
            $display("FAIL rnd_starve: cycle %0d src %0d waited %0d, expected <= %0d", c, i, waitc[i], WAIT_MAX);
          end
        end else begin
          pv[i] = ($urandom_range(2) == 0);
        end
      end
      nfull = ($urandom_range(4) == 0);
      tick();
    end
    checks++;
    if (writes < 1000) begin
      errors++;
      $display("FAIL rnd_throughput: got %0d writes, expected >= 1000", writes);
    end
    req_valid = '0;
    fifo_full = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_valid();
    test_full_stall();
    test_dropout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
